// File: rtl/axis_cobs_pkg.sv
// Shared COBS definitions used by both the encoder and the decoder:
// the decoder state enum and the delimiter / maximum code byte values.
`timescale 1ns/1ps
package axis_cobs_pkg;

  typedef enum logic {
    CODE = 1'b0,  // next byte is a code byte
    DATA = 1'b1   // count bytes remain in the current block
  } cobs_state_e;

  localparam logic [7:0] COBS_DELIM    = 8'h00;
  localparam logic [7:0] COBS_CODE_MAX = 8'hFF;

endpackage

// File: rtl/axis_cobs_if.sv
// Byte-wide AXI-Stream bundle with tlast/tuser. The master drives data and
// sideband signals, the slave drives tready.
`timescale 1ns/1ps
interface axis_cobs_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/axis_cobs_out_stage.sv
// Hold register plus registered output beat. A decoded byte waits in hold
// until the decoder knows whether it is the last byte of its frame: a later
// push releases it with tlast=0, an end of frame marks it last and it drains
// as soon as the output register is free. An error-only frame with nothing
// held becomes a synthetic 0x00 last beat carrying tuser=1.
`timescale 1ns/1ps
module axis_cobs_out_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       eof_i,
  input  logic       eof_user_i,
  output logic       ready_o,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic       m_tuser_o
);

  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_valid_q, hold_valid_d;
  logic       hold_last_q, hold_last_d;
  logic       hold_user_q, hold_user_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic       m_user_q, m_user_d;
  logic       out_free;

  assign out_free = !m_valid_q || m_tready_i;
  assign ready_o  = !hold_valid_q || out_free;

  // Next-state for hold and output: drain, push, end of frame, drain again.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    hold_user_d  = hold_user_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_user_d     = m_user_q;
    m_valid_d    = m_valid_q && !m_tready_i;

    // A hold already marked last leaves first, so a new frame never edits it.
    if (hold_valid_d && hold_last_d && !m_valid_d) begin
      m_valid_d    = 1'b1;
      m_data_d     = hold_data_d;
      m_last_d     = 1'b1;
      m_user_d     = hold_user_d;
      hold_valid_d = 1'b0;
      hold_last_d  = 1'b0;
    end

    if (push_i) begin
      if (hold_valid_d) begin
        m_valid_d = 1'b1;
        m_data_d  = hold_data_d;
        m_last_d  = 1'b0;
        m_user_d  = 1'b0;
      end
      hold_data_d  = push_data_i;
      hold_valid_d = 1'b1;
      hold_last_d  = 1'b0;
      hold_user_d  = 1'b0;
    end

    if (eof_i) begin
      if (hold_valid_d && !hold_last_d) begin
        hold_last_d = 1'b1;
        hold_user_d = eof_user_i;
      end else if (eof_user_i) begin
        hold_data_d  = 8'h00;
        hold_valid_d = 1'b1;
        hold_last_d  = 1'b1;
        hold_user_d  = 1'b1;
      end
    end

    // Frame end with a free output register emits its last beat next cycle.
    if (hold_valid_d && hold_last_d && !m_valid_d) begin
      m_valid_d    = 1'b1;
      m_data_d     = hold_data_d;
      m_last_d     = 1'b1;
      m_user_d     = hold_user_d;
      hold_valid_d = 1'b0;
      hold_last_d  = 1'b0;
    end
  end

  // Hold and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, so the output bus reads 0 after reset.
    if (!rst_n) begin
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      hold_user_q  <= 1'b0;
      m_data_q     <= 8'h00;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update simultaneous.
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      hold_user_q  <= hold_user_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
    end
  end

  assign m_tdata_o  = m_data_q;
  assign m_tvalid_o = m_valid_q;
  assign m_tlast_o  = m_last_q;
  assign m_tuser_o  = m_user_q;

endmodule

// File: rtl/axis_cobs_decode.sv
// Byte-wide AXI-Stream COBS decoder. Frames end on a 0x00 delimiter and/or
// input tlast; truncated blocks and upstream tuser mark the frame bad.
// Optional feature macro: AXIS_COBS_DECODE_ERR_CNT_EN adds err_count, a
// saturating count of bad frames handed downstream.
`timescale 1ns/1ps
module axis_cobs_decode
  import axis_cobs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  axis_cobs_if.slave  s_axis,
  axis_cobs_if.master m_axis
`ifdef AXIS_COBS_DECODE_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  cobs_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        zero_pend_q, zero_pend_d;
  logic        err_q, err_d;
  logic        ready, accept, err_now;
  logic        push, eof, eof_user;
  logic [7:0]  push_data;

  assign s_axis.tready = ready;
  assign accept        = s_axis.tvalid && ready;
  assign err_now       = err_q || s_axis.tuser;

  // Decode one accepted byte: code/data handling, then end-of-frame cleanup.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    zero_pend_d = zero_pend_q;
    err_d       = err_q;
    push        = 1'b0;
    push_data   = s_axis.tdata;
    eof         = 1'b0;
    eof_user    = 1'b0;

    if (accept) begin
      err_d = err_now;
      if (s_axis.tdata == COBS_DELIM) begin
        eof      = 1'b1;
        eof_user = err_now || (count_q != 8'h00);
      end else begin
        if (state_q == CODE) begin
          push        = zero_pend_q;
          push_data   = COBS_DELIM;
          zero_pend_d = (s_axis.tdata != COBS_CODE_MAX);
          count_d     = s_axis.tdata - 8'd1;
          state_d     = (count_d != 8'h00) ? DATA : CODE;
        end else begin
          push    = 1'b1;
          count_d = count_q - 8'd1;
          if (count_d == 8'h00) state_d = CODE;
        end
        if (s_axis.tlast) begin
          eof      = 1'b1;
          eof_user = err_now || (count_d != 8'h00);
        end
      end

      if (eof) begin
        state_d     = CODE;
        count_d     = 8'h00;
        zero_pend_d = 1'b0;
        err_d       = 1'b0;
      end
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CODE;
      count_q     <= 8'h00;
      zero_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      zero_pend_q <= zero_pend_d;
      err_q       <= err_d;
    end
  end

  axis_cobs_out_stage u_out_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .eof_i       (eof),
    .eof_user_i  (eof_user),
    .ready_o     (ready),
    .m_tdata_o   (m_axis.tdata),
    .m_tvalid_o  (m_axis.tvalid),
    .m_tready_i  (m_axis.tready),
    .m_tlast_o   (m_axis.tlast),
    .m_tuser_o   (m_axis.tuser)
  );

`ifdef AXIS_COBS_DECODE_ERR_CNT_EN
  logic [15:0] err_count_q;

  // Count bad frames on the handshake of their last beat, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 16'h0000;
    end else if (m_axis.tvalid && m_axis.tready && m_axis.tlast && m_axis.tuser
                 && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
